slurm32_cpu_divider: RTL and testbench

Multi-cycle iterative integer divider for the SLURM32 execute stage, the inverse of the ALU's single-cycle multiplier. It accepts a dividend/divisor pair on a start strobe and runs one restoring-division step per clock. It returns quotient, remainder and a flag nibble in the same C/Z/S/V layout as the ALU flags. The pipeline stalls on `busy` and captures the results on the one-cycle `done` pulse.

---
 rtl/slurm32_cpu_divider.sv | 168 ++++++++++++++++
 tb/tb_slurm32_cpu_divider.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_cpu_divider.sv
// Iterative restoring divider for the SLURM32 execute stage: one quotient bit per clock,
// with signed/unsigned operands, divide-by-zero and overflow flags, and abort support.
module slurm32_cpu_divider #(
    parameter int BITS = 32
) (
    input  logic            CLK,
    input  logic            RSTb,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            start,
    input  logic            is_signed,
    input  logic            abort,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            C,
    output logic            Z,
    output logic            S,
    output logic            V
);

    localparam int CW = $clog2(BITS);
    localparam logic [BITS-1:0] MostNeg = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } stateT;

    stateT           state;
    stateT           nextState;

    logic [BITS-1:0] aReg;
    logic [BITS-1:0] bReg;
    logic            signedReg;
    logic [BITS-1:0] dvd;
    logic [BITS-1:0] dvsr;
    logic [BITS-1:0] rem;
    logic [CW-1:0]   count;
    logic            negQ;
    logic            negR;
    logic            divZero;

    logic [BITS-1:0] absA;
    logic [BITS-1:0] absB;
    logic [BITS:0]   remShift;
    logic [BITS:0]   diff;
    logic            qBit;
    logic            lastStep;
    logic [BITS-1:0] qFinal;
    logic [BITS-1:0] rFinal;
    logic            overflow;

    // The most-negative operand negates to itself, which reads correctly as unsigned 2^(BITS-1).
    assign absA     = (signedReg && aReg[BITS-1]) ? -aReg : aReg;
    assign absB     = (signedReg && bReg[BITS-1]) ? -bReg : bReg;

    assign remShift = {rem, dvd[BITS-1]};
    assign diff     = remShift - {1'b0, dvsr};
    assign qBit     = ~diff[BITS];
    assign lastStep = (count == CW'(BITS - 1));

    assign qFinal   = negQ ? -dvd : dvd;
    assign rFinal   = negR ? -rem : rem;
    assign overflow = signedReg && (aReg == MostNeg) && (bReg == '1);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = PREP;
            PREP: begin
                if (abort)            nextState = IDLE;
                else if (bReg == '0)  nextState = FIXUP;
                else                  nextState = ITER;
            end
            ITER: begin
                if (abort)            nextState = IDLE;
                else if (lastStep)    nextState = FIXUP;
            end
            FIXUP:   nextState = abort ? IDLE : DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            aReg      <= '0;
            bReg      <= '0;
            signedReg <= 1'b0;
            dvd       <= '0;
            dvsr      <= '0;
            rem       <= '0;
            count     <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            divZero   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            C         <= 1'b0;
            Z         <= 1'b0;
            S         <= 1'b0;
            V         <= 1'b0;
        end else begin
            busy <= (nextState == PREP) || (nextState == ITER) || (nextState == FIXUP);
            done <= (nextState == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg      <= A;
                        bReg      <= B;
                        signedReg <= is_signed;
                    end
                end
                PREP: begin
                    dvd     <= absA;
                    dvsr    <= absB;
                    rem     <= '0;
                    count   <= '0;
                    negQ    <= signedReg & (aReg[BITS-1] ^ bReg[BITS-1]);
                    negR    <= signedReg & aReg[BITS-1];
                    divZero <= (bReg == '0);
                end
                ITER: begin
                    rem   <= qBit ? diff[BITS-1:0] : remShift[BITS-1:0];
                    dvd   <= {dvd[BITS-2:0], qBit};
                    count <= count + 1'b1;
                end
                FIXUP: begin
                    // An abort landing on the fixup cycle must leave the previous results intact.
                    if (!abort) begin
                        if (divZero) begin
                            quotient  <= '1;
                            remainder <= aReg;
                            C         <= 1'b1;
                            Z         <= 1'b0;
                            S         <= 1'b1;
                            V         <= 1'b0;
                        end else begin
                            quotient  <= qFinal;
                            remainder <= rFinal;
                            C         <= 1'b0;
                            Z         <= (qFinal == '0);
                            S         <= qFinal[BITS-1];
                            V         <= overflow;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slurm32_cpu_divider.sv
// Directed self-checking bench for slurm32_cpu_divider (BITS=32): latency, flags,
// divide-by-zero, overflow, abort, asynchronous reset and back-to-back operation.
module tb_slurm32_cpu_divider;

    logic        CLK;
    logic        RSTb;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        is_signed;
    logic        abort;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        C;
    logic        Z;
    logic        S;
    logic        V;

    int vectors;
    int miscompares;

    slurm32_cpu_divider #(.BITS(32)) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .A         (A),
        .B         (B),
        .start     (start),
        .is_signed (is_signed),
        .abort     (abort),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .C         (C),
        .Z         (Z),
        .S         (S),
        .V         (V)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issues one start pulse; returns at the negedge following the sampling edge (edge 0).
    task automatic doStart(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge CLK);
        for (int i = 0; i < 4 && done; i++) @(negedge CLK);
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Counts edges after edge 0 until done is seen; edges stays 0 on timeout.
    task automatic waitDone(output int edges, output bit busyDropped);
        edges = 0;
        busyDropped = 1'b0;
        for (int i = 1; i <= 60 && edges == 0; i++) begin
            @(posedge CLK);
            #1;
            if (done) edges = i;
            else if (!busy) busyDropped = 1'b1;
        end
    endtask

    task automatic test_reset;
        RSTb = 1'b0;
        A = '0;
        B = '0;
        start = 1'b0;
        is_signed = 1'b0;
        abort = 1'b0;
        #12;
        vectors++;
        if ({quotient, remainder, busy, done, C, Z, S, V} !== 70'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got q=%h r=%h busy=%b done=%b CZSV=%b%b%b%b, want all zero",
                     quotient, remainder, busy, done, C, Z, S, V);
        end
        @(negedge CLK);
        RSTb = 1'b1;
    endtask

    task automatic test_unsigned;
        int edges;
        bit dropped;
        doStart(32'd100, 32'd7, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL unsigned_busy_after_start: got %b want 1", busy);
        end
        waitDone(edges, dropped);
        vectors++;
        if (edges !== 34) begin
            miscompares++;
            $display("[TB] FAIL unsigned_latency: got %0d edges want 34", edges);
        end
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unsigned_busy_held: busy dropped early (got %b want 0)", dropped);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unsigned_busy_at_done: got %b want 0", busy);
        end
        vectors++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL unsigned_result: got q=%0d r=%0d want q=14 r=2", quotient, remainder);
        end
        vectors++;
        if ({C, Z, S, V} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL unsigned_flags: got CZSV=%b want 0000", {C, Z, S, V});
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unsigned_done_pulse: got done=%b one cycle later want 0", done);
        end
    endtask

    task automatic test_signed;
        int edges;
        bit dropped;
        doStart(32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL signed_result: got q=%h r=%h want q=fffffffd r=ffffffff", quotient, remainder);
        end
        vectors++;
        if ({C, Z, S, V} !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL signed_flags: got CZSV=%b want 0010", {C, Z, S, V});
        end
        doStart(32'hFFFF_FFF9, 32'd2, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL unsigned_big_result: got q=%h r=%h want q=7ffffffc r=1", quotient, remainder);
        end
    endtask

    task automatic test_div_zero;
        int edges;
        bit dropped;
        doStart(32'd5, 32'd0, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (edges !== 2) begin
            miscompares++;
            $display("[TB] FAIL divzero_latency: got %0d edges want 2", edges);
        end
        vectors++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || C !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL divzero_result: got q=%h r=%h C=%b want q=ffffffff r=5 C=1", quotient, remainder, C);
        end
        doStart(32'd0, 32'd3, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'd0 || remainder !== 32'd0 || {C, Z, S, V} !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL zero_dividend: got q=%h r=%h CZSV=%b want q=0 r=0 CZSV=0100",
                     quotient, remainder, {C, Z, S, V});
        end
    endtask

    task automatic test_overflow;
        int edges;
        bit dropped;
        doStart(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL overflow_result: got q=%h r=%h want q=80000000 r=0", quotient, remainder);
        end
        vectors++;
        if ({C, Z, S, V} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL overflow_flags: got CZSV=%b want 0011", {C, Z, S, V});
        end
    endtask

    task automatic test_abort;
        int edges;
        int doneSeen;
        bit dropped;
        doStart(32'd1000, 32'd3, 1'b0);
        repeat (3) @(negedge CLK);
        A = 32'd77;
        B = 32'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (7) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_busy: got %b want 0", busy);
        end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (done || busy) doneSeen++;
        end
        vectors++;
        if (doneSeen !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles want 0", doneSeen);
        end
        vectors++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || {C, Z, S, V} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL abort_held: got q=%h r=%h CZSV=%b want q=80000000 r=0 CZSV=0011",
                     quotient, remainder, {C, Z, S, V});
        end
        doStart(32'd9, 32'd3, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'd3 || remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_restart: got q=%0d r=%0d want q=3 r=0", quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op;
        int edges;
        int doneSeen;
        bit dropped;
        doStart(32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge CLK);
        #2;
        RSTb = 1'b0;
        #1;
        vectors++;
        if ({quotient, remainder, busy, done, C, Z, S, V} !== 70'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got q=%h r=%h busy=%b done=%b CZSV=%b%b%b%b, want all zero",
                     quotient, remainder, busy, done, C, Z, S, V);
        end
        @(negedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (done || busy) doneSeen++;
        end
        vectors++;
        if (doneSeen !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_no_done: got %0d active cycles want 0", doneSeen);
        end
        doStart(32'd20, 32'd4, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'd5 || remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_restart: got q=%0d r=%0d want q=5 r=0", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int edges;
        bit dropped;
        doStart(32'd50, 32'd5, 1'b0);
        waitDone(edges, dropped);
        vectors++;
        if (quotient !== 32'd10 || remainder !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got q=%0d r=%0d want q=10 r=0", quotient, remainder);
        end
        @(negedge CLK);
        A = 32'd80;
        B = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_start_in_done: got busy=%b want 0", busy);
        end
        @(negedge CLK);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_start_in_idle: got busy=%b want 1", busy);
        end
        waitDone(edges, dropped);
        vectors++;
        if (edges !== 34 || quotient !== 32'd11 || remainder !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got edges=%0d q=%0d r=%0d want edges=34 q=11 r=3",
                     edges, quotient, remainder);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
